// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: states, opcode/funct constants and datapath select encodings for the multicycle control
package mips_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RESET, S_FETCH, S_DECODE, S_R_EX, S_R_WB, S_ADDI_EX, S_ADDI_WB,
        S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_JAL, S_JR,
        S_EXC, S_HALT
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_BREAK = 6'h0D;

    typedef enum logic [1:0] {RD_RT, RD_RD, RD_RA, RD_RSVD} reg_dst_t;
    typedef enum logic [1:0] {MR_ALU, MR_MDR, MR_PC} mem_to_reg_t;
    typedef enum logic [1:0] {SB_B, SB_FOUR, SB_IMM, SB_IMM_SH} alu_src_b_t;
    typedef enum logic [1:0] {AO_ADD, AO_SUB, AO_FUNCT} alu_op_t;
    typedef enum logic [1:0] {PS_ALU, PS_ALUOUT, PS_JUMP, PS_EXC} pc_source_t;

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM sequencing fetch/decode/execute/mem/writeback of the multicycle MIPS
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    input  logic       alu_overflow,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       i_or_d,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       exc_active
);

    state_t state, next_state;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_RESET;
        else          state <= next_state;
    end

    always_comb begin
        next_state    = state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        i_or_d        = 1'b0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = RD_RT;
        mem_to_reg    = MR_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = SB_B;
        alu_op        = AO_ADD;
        pc_source     = PS_ALU;
        exc_active    = 1'b0;
        case (state)
            S_RESET: next_state = S_FETCH;
            S_FETCH: begin
                mem_rd     = 1'b1;
                alu_src_b  = SB_FOUR;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                next_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = SB_IMM_SH;
                case (opcode)
                    OP_R:          next_state = funct == FN_JR    ? S_JR   :
                                                funct == FN_BREAK ? S_HALT : S_R_EX;
                    OP_LW, OP_SW:  next_state = S_MEMADR;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_ADDI:       next_state = S_ADDI_EX;
                    OP_J:          next_state = S_JUMP;
                    OP_JAL:        next_state = S_JAL;
                    default:       next_state = S_EXC;
                endcase
            end
            S_R_EX: begin
                alu_src_a  = 1'b1;
                alu_op     = AO_FUNCT;
                next_state = alu_overflow ? S_EXC : S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = RD_RD;
                next_state = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SB_IMM;
                next_state = alu_overflow ? S_EXC : S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SB_IMM;
                next_state = opcode == OP_SW ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_rd     = 1'b1;
                i_or_d     = 1'b1;
                next_state = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = MR_MDR;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                mem_wr     = 1'b1;
                i_or_d     = 1'b1;
                next_state = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = AO_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PS_ALUOUT;
                branch_ne     = opcode == OP_BNE;
                next_state    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PS_JUMP;
                next_state = S_FETCH;
            end
            S_JAL: begin
                reg_write  = 1'b1;
                reg_dst    = RD_RA;
                mem_to_reg = MR_PC;
                pc_write   = 1'b1;
                pc_source  = PS_JUMP;
                next_state = S_FETCH;
            end
            S_JR: begin
                alu_src_a  = 1'b1;
                pc_write   = 1'b1;
                next_state = S_FETCH;
            end
            S_EXC: begin
                exc_active = 1'b1;
                pc_write   = 1'b1;
                pc_source  = PS_EXC;
                next_state = S_FETCH;
            end
            S_HALT: next_state = S_HALT;
            default: next_state = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed table, corner sequences and random instruction traces for the control FSM
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_rd, mem_wr, ir_write, reg_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
        logic       exc_active;
    } out_t;

    typedef struct {
        logic       rn;
        logic [5:0] op, fn;
        logic       mr, ov;
        out_t       exp;
        string      nm;
    } vec_t;

    localparam int P_ZERO = 0, P_FW = 1, P_FG = 2, P_DEC = 3, P_REX = 4, P_RWB = 5,
                   P_AEX = 6, P_AWB = 7, P_MA = 8, P_MR = 9, P_MWB = 10, P_MW = 11,
                   P_BR = 12, P_J = 13, P_JAL = 14, P_JR = 15, P_EXC = 16;

    logic clk = 1'b0, reset_n = 1'b0, mem_ready = 1'b0, alu_overflow = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic pc_write, pc_write_cond, branch_ne, i_or_d, mem_rd, mem_wr, ir_write, reg_write, alu_src_a, exc_active;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
    out_t got;
    int checks = 0, errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .alu_overflow(alu_overflow),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .i_or_d(i_or_d), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .exc_active(exc_active)
    );

    assign got = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_rd, mem_wr, ir_write, reg_write,
                  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, exc_active};

    // Expected outputs of each control step, straight from the per-state output rules
    function automatic out_t ph(input int p, input logic bne);
        out_t o;
        o = '0;
        case (p)
            P_FW:  begin o.mem_rd = 1; o.alu_src_b = 1; end
            P_FG:  begin o.mem_rd = 1; o.alu_src_b = 1; o.ir_write = 1; o.pc_write = 1; end
            P_DEC: o.alu_src_b = 3;
            P_REX: begin o.alu_src_a = 1; o.alu_op = 2; end
            P_RWB: begin o.reg_write = 1; o.reg_dst = 1; end
            P_AEX, P_MA: begin o.alu_src_a = 1; o.alu_src_b = 2; end
            P_AWB: o.reg_write = 1;
            P_MR:  begin o.mem_rd = 1; o.i_or_d = 1; end
            P_MWB: begin o.reg_write = 1; o.mem_to_reg = 1; end
            P_MW:  begin o.mem_wr = 1; o.i_or_d = 1; end
            P_BR:  begin o.alu_src_a = 1; o.alu_op = 1; o.pc_write_cond = 1; o.pc_source = 1; o.branch_ne = bne; end
            P_J:   begin o.pc_write = 1; o.pc_source = 2; end
            P_JAL: begin o.reg_write = 1; o.reg_dst = 2; o.mem_to_reg = 2; o.pc_write = 1; o.pc_source = 2; end
            P_JR:  begin o.alu_src_a = 1; o.pc_write = 1; end
            P_EXC: begin o.exc_active = 1; o.pc_write = 1; o.pc_source = 3; end
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step(input logic rn, input logic [5:0] op, input logic [5:0] fn,
                        input logic mr, input logic ov, input out_t e, input string nm);
        reset_n = rn; opcode = op; funct = fn; mem_ready = mr; alu_overflow = ov;
        @(negedge clk);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s op=%h fn=%h: got %h expected %h", nm, op, fn, got, e);
        end
        @(posedge clk);
        #1;
    endtask

    // Builds the cycle trace of one instruction from its class, wait counts and overflow
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw, input logic ov);
        for (int i = 0; i < fw; i++) step(1, op, fn, 0, rb(), ph(P_FW, 0), "fetch_wait");
        step(1, op, fn, 1, rb(), ph(P_FG, 0), "fetch");
        step(1, op, fn, rb(), rb(), ph(P_DEC, 0), "decode");
        case (op)
            6'h00: if (fn == 6'h08) step(1, op, fn, rb(), rb(), ph(P_JR, 0), "jr");
                   else begin
                       step(1, op, fn, rb(), ov, ph(P_REX, 0), "r_ex");
                       step(1, op, fn, rb(), rb(), ph(ov ? P_EXC : P_RWB, 0), ov ? "r_exc" : "r_wb");
                   end
            6'h08: begin
                step(1, op, fn, rb(), ov, ph(P_AEX, 0), "addi_ex");
                step(1, op, fn, rb(), rb(), ph(ov ? P_EXC : P_AWB, 0), ov ? "addi_exc" : "addi_wb");
            end
            6'h23: begin
                step(1, op, fn, rb(), rb(), ph(P_MA, 0), "lw_adr");
                for (int i = 0; i < mw; i++) step(1, op, fn, 0, rb(), ph(P_MR, 0), "lw_wait");
                step(1, op, fn, 1, rb(), ph(P_MR, 0), "lw_rd");
                step(1, op, fn, rb(), rb(), ph(P_MWB, 0), "lw_wb");
            end
            6'h2B: begin
                step(1, op, fn, rb(), rb(), ph(P_MA, 0), "sw_adr");
                for (int i = 0; i < mw; i++) step(1, op, fn, 0, rb(), ph(P_MW, 0), "sw_wait");
                step(1, op, fn, 1, rb(), ph(P_MW, 0), "sw_wr");
            end
            6'h04, 6'h05: step(1, op, fn, rb(), rb(), ph(P_BR, op == 6'h05), "branch");
            6'h02: step(1, op, fn, rb(), rb(), ph(P_J, 0), "jump");
            6'h03: step(1, op, fn, rb(), rb(), ph(P_JAL, 0), "jal");
            default: step(1, op, fn, rb(), rb(), ph(P_EXC, 0), "illegal");
        endcase
    endtask

    task automatic addv(input logic [5:0] op, input logic [5:0] fn, input logic mr, input logic ov, input out_t e, input string nm);
        vec_t v;
        v.rn = 1; v.op = op; v.fn = fn; v.mr = mr; v.ov = ov; v.exp = e; v.nm = nm;
        tbl.push_back(v);
    endtask

    initial begin
        logic [5:0] op, fn;
        addv(6'h00, 6'h20, 0, 0, ph(P_ZERO, 0), "reset_state");
        addv(6'h00, 6'h20, 1, 0, ph(P_FG, 0), "r_fetch");
        addv(6'h00, 6'h20, 0, 0, ph(P_DEC, 0), "r_decode");
        addv(6'h00, 6'h20, 0, 0, ph(P_REX, 0), "r_ex");
        addv(6'h00, 6'h20, 0, 0, ph(P_RWB, 0), "r_wb");
        addv(6'h03, 6'h00, 1, 0, ph(P_FG, 0), "jal_fetch");
        addv(6'h03, 6'h00, 0, 0, ph(P_DEC, 0), "jal_decode");
        addv(6'h03, 6'h00, 0, 0, ph(P_JAL, 0), "jal");
        addv(6'h05, 6'h00, 0, 0, ph(P_FW, 0), "bne_fetch_wait");
        addv(6'h05, 6'h00, 1, 0, ph(P_FG, 0), "bne_fetch");
        addv(6'h05, 6'h00, 0, 0, ph(P_DEC, 0), "bne_decode");
        addv(6'h05, 6'h00, 0, 0, ph(P_BR, 1), "bne");
        addv(6'h3F, 6'h00, 1, 0, ph(P_FG, 0), "ill_fetch");
        addv(6'h3F, 6'h00, 0, 0, ph(P_DEC, 0), "ill_decode");
        addv(6'h3F, 6'h00, 0, 0, ph(P_EXC, 0), "ill_exc");
        addv(6'h08, 6'h00, 1, 0, ph(P_FG, 0), "addi_fetch");
        addv(6'h08, 6'h00, 0, 0, ph(P_DEC, 0), "addi_decode");
        addv(6'h08, 6'h00, 0, 1, ph(P_AEX, 0), "addi_ex_ovf");
        addv(6'h08, 6'h00, 0, 0, ph(P_EXC, 0), "addi_exc");
        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[i]) step(tbl[i].rn, tbl[i].op, tbl[i].fn, tbl[i].mr, tbl[i].ov, tbl[i].exp, tbl[i].nm);
        // Reset asserted while a load waits on memory
        step(1, 6'h23, 0, 1, 0, ph(P_FG, 0), "rst_lw_fetch");
        step(1, 6'h23, 0, 0, 0, ph(P_DEC, 0), "rst_lw_decode");
        step(1, 6'h23, 0, 0, 0, ph(P_MA, 0), "rst_lw_adr");
        step(1, 6'h23, 0, 0, 0, ph(P_MR, 0), "rst_lw_wait");
        step(0, 6'h23, 0, 1, 1, ph(P_MR, 0), "rst_edge_pending");
        step(0, 6'h23, 0, 1, 1, ph(P_ZERO, 0), "rst_mid_memrd");
        step(1, 6'h23, 0, 1, 1, ph(P_ZERO, 0), "rst_release");
        run_instr(6'h23, 6'h00, 0, 3, 0);
        run_instr(6'h2B, 6'h00, 0, 2, 0);
        run_instr(6'h00, 6'h08, 1, 0, 0);
        step(1, 6'h00, 6'h0D, 1, 0, ph(P_FG, 0), "brk_fetch");
        step(1, 6'h00, 6'h0D, 0, 0, ph(P_DEC, 0), "brk_decode");
        for (int i = 0; i < 10; i++) step(1, 6'h00, 6'h0D, rb(), rb(), ph(P_ZERO, 0), "halt");
        step(0, 6'h00, 6'h0D, 1, 0, ph(P_ZERO, 0), "halt_reset");
        step(1, 6'h00, 6'h0D, 1, 0, ph(P_ZERO, 0), "halt_reset_release");
        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 9))
                0: op = 6'h00; 1: op = 6'h23; 2: op = 6'h2B; 3: op = 6'h04; 4: op = 6'h05;
                5: op = 6'h08; 6: op = 6'h02; 7: op = 6'h03; 8: op = 6'h00;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    if (op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B}) op = 6'h3E;
                end
            endcase
            fn = ($urandom_range(0, 4) == 0) ? 6'h08 : 6'($urandom_range(0, 63));
            if (fn == 6'h0D) fn = 6'h20;
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
